// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          LAT_W     = 3;

endpackage

// File: rtl/fetch_latency_counter.sv
// ROM wait counter: loads MEM_LATENCY, counts down, flags the last wait cycle.
module fetch_latency_counter
  import fetch_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  if (MEM_LATENCY < 0 || MEM_LATENCY > 7) begin : g_bad_latency
    $error("fetch_latency_counter: MEM_LATENCY must be in 0..7");
  end

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LAT_W'(MEM_LATENCY);
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - LAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  // A count of 1 marks the final wait cycle; 0 guards against a stuck WAIT.
  assign tc_o = (cnt_q <= LAT_W'(1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC/old-PC, ROM word indexing, latency wait and IR capture.
// Optional build macro PC_AUTOINC_EN advances PC to old_pc+4 at fetch completion.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 'h0040_0000,
  parameter int                    MEM_LATENCY  = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  fetch_start_i,
  input  logic                  pc_write_i,
  input  logic [DATA_WIDTH-1:0] pc_next_i,
  input  logic [DATA_WIDTH-1:0] mem_instr_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] old_pc_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  fetch_busy_o,
  output logic                  fetch_done_o,
  output logic                  fetch_fault_o
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] old_pc_q, old_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] word_idx;
  logic                  pc_bad;
  logic                  accept;
  logic                  lat_load, lat_dec, lat_tc;
  logic                  capture_rom;

  // Unsigned subtract wraps for pc < TEXT_BASE; the explicit compare catches that case.
  assign word_idx = (pc_q - TEXT_BASE) >> 2;
  assign pc_bad   = (pc_q[1:0] != 2'b00)
                  || (pc_q < TEXT_BASE)
                  || (word_idx >= DATA_WIDTH'(MEMORY_DEPTH));
  assign accept   = (state_q == IDLE) && fetch_start_i;

  fetch_latency_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_lat (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (lat_load),
    .dec_i    (lat_dec),
    .tc_o     (lat_tc)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A faulting fetch jumps straight to CAPTURE so done follows one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_start_i) state_d = pc_bad ? CAPTURE : ADDR;
      ADDR:    state_d = (MEM_LATENCY == 0) ? CAPTURE : WAIT;
      WAIT:    if (lat_tc) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_busy_o = (state_q != IDLE);
    fetch_done_o = (state_q == CAPTURE);
    lat_load     = (state_q == ADDR);
    lat_dec      = (state_q == WAIT);
  end

  assign capture_rom = (state_q == CAPTURE) && !fault_q;

  always_comb begin
    old_pc_d   = old_pc_q;
    instr_d    = instr_q;
    mem_addr_d = mem_addr_q;
    fault_d    = fault_q;
    if (accept) begin
      old_pc_d = pc_q;
      fault_d  = pc_bad;
      if (pc_bad) instr_d    = NOP_W;
      else        mem_addr_d = word_idx;
    end
    if (capture_rom) instr_d = mem_instr_i;
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_write_i)
      pc_d = pc_next_i;
`ifdef PC_AUTOINC_EN
    else if (state_q == CAPTURE)
      pc_d = old_pc_q + DATA_WIDTH'(4);
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q       <= TEXT_BASE;
      old_pc_q   <= TEXT_BASE;
      instr_q    <= NOP_W;
      mem_addr_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      old_pc_q   <= old_pc_d;
      instr_q    <= instr_d;
      mem_addr_q <= mem_addr_d;
      fault_q    <= fault_d;
    end
  end

  // ROM word is forwarded during CAPTURE so IR reads valid alongside fetch_done.
  assign instr_o       = capture_rom ? mem_instr_i : instr_q;
  assign mem_addr_o    = mem_addr_q;
  assign pc_o          = pc_q;
  assign old_pc_o      = old_pc_q;
  assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: three latency variants driven in lockstep vs a transaction model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          NI   = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0, pw = 1'b0;
  logic [31:0] pn = '0;
  logic [31:0] rom [64];

  logic [31:0] mem_instr [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] pc        [NI];
  logic [31:0] old_pc    [NI];
  logic [31:0] instr     [NI];
  logic        busy      [NI];
  logic        done      [NI];
  logic        fault     [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    instruction_fetch_unit #(.MEM_LATENCY(lat_of(g))) u_dut (
      .clk_i         (clk),
      .reset_ni      (rst_n),
      .fetch_start_i (fs),
      .pc_write_i    (pw),
      .pc_next_i     (pn),
      .mem_instr_i   (mem_instr[g]),
      .mem_addr_o    (mem_addr[g]),
      .pc_o          (pc[g]),
      .old_pc_o      (old_pc[g]),
      .instr_o       (instr[g]),
      .fetch_busy_o  (busy[g]),
      .fetch_done_o  (done[g]),
      .fetch_fault_o (fault[g])
    );
    assign mem_instr[g] = rom[mem_addr[g][5:0]];
  end

  // Transaction-level model: each fetch is an accept cycle plus the cycle its done appears.
  logic [31:0] m_pc [NI], m_old [NI], m_instr [NI], m_pend [NI], m_addr [NI];
  logic        m_fault [NI];
  int          m_acc [NI], m_done [NI];
  int          cyc = 0;
  int          n_cmp = 0, n_mis = 0;

  function automatic bit bad_pc(input logic [31:0] p);
    return (p % 4 != 0) || (p < BASE) || ((p - BASE) / 4 >= 64);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < NI; m++) begin
      m_pc[m] = BASE; m_old[m] = BASE; m_instr[m] = NOP; m_pend[m] = NOP;
      m_addr[m] = '0; m_fault[m] = 1'b0; m_acc[m] = -1; m_done[m] = -1;
    end
  endtask

  task automatic model_update(input logic f, input logic w, input logic [31:0] n);
    for (int m = 0; m < NI; m++) begin
      logic        idle;
      logic [31:0] pc_new;
      idle = (cyc > m_done[m]);
      if (cyc == m_done[m]) m_instr[m] = m_pend[m];
      pc_new = m_pc[m];
      if (w) pc_new = n;
`ifdef PC_AUTOINC_EN
      else if (cyc == m_done[m]) pc_new = m_old[m] + 4;
`endif
      if (f && idle) begin
        m_acc[m] = cyc;
        m_old[m] = m_pc[m];
        if (bad_pc(m_pc[m])) begin
          m_fault[m] = 1'b1; m_instr[m] = NOP; m_pend[m] = NOP; m_done[m] = cyc + 1;
        end else begin
          m_fault[m] = 1'b0;
          m_addr[m]  = (m_pc[m] - BASE) / 4;
          m_pend[m]  = rom[m_addr[m][5:0]];
          m_done[m]  = cyc + 2 + lat_of(m);
        end
      end
      m_pc[m] = pc_new;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < NI; m++) begin
      chk($sformatf("c%0d u%0d mem_addr", cyc, m), mem_addr[m], m_addr[m]);
      chk($sformatf("c%0d u%0d pc", cyc, m), pc[m], m_pc[m]);
      chk($sformatf("c%0d u%0d old_pc", cyc, m), old_pc[m], m_old[m]);
      chk($sformatf("c%0d u%0d instr", cyc, m), instr[m],
          (cyc == m_done[m]) ? m_pend[m] : m_instr[m]);
      chk($sformatf("c%0d u%0d busy", cyc, m), 32'(busy[m]),
          32'(cyc > m_acc[m] && cyc <= m_done[m]));
      chk($sformatf("c%0d u%0d done", cyc, m), 32'(done[m]), 32'(cyc == m_done[m]));
      chk($sformatf("c%0d u%0d fault", cyc, m), 32'(fault[m]), 32'(m_fault[m]));
    end
  endtask

  // Called at a falling edge: drive, clock, advance model, check at the next falling edge.
  task automatic step(input logic f, input logic w, input logic [31:0] n);
    fs = f; pw = w; pn = n;
    @(posedge clk);
    model_update(f, w, n);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h0050_0093;
    model_reset();

    // Reset values, during and after reset
    @(negedge clk);
    check_all();
    chk("rst pc", pc[1], 32'h0040_0000);
    chk("rst instr", instr[1], 32'h0000_0013);
    rst_n = 1'b1;
    #1 check_all();

    // Good fetch at word 0; second start while busy is ignored
    step(1'b1, 1'b0, '0);
    chk("fetch0 mem_addr", mem_addr[1], 32'd0);
    step(1'b1, 1'b0, '0);
    chk("lat0 done +2", 32'(done[0]), 32'd1);
    step(1'b0, 1'b0, '0);
    chk("lat1 done +3", 32'(done[1]), 32'd1);
    chk("lat1 instr", instr[1], 32'h0050_0093);
    chk("lat1 old_pc", old_pc[1], 32'h0040_0000);
    idle(2);
    chk("lat3 done +5", 32'(done[2]), 32'd1);
    idle(1);

    // Misaligned PC faults; out-of-range index faults; a good fetch clears it
    step(1'b0, 1'b1, BASE + 32'h2);
    step(1'b1, 1'b0, '0);
    chk("misalign fault", 32'(fault[1]), 32'd1);
    chk("misalign done", 32'(done[1]), 32'd1);
    chk("misalign instr", instr[1], NOP);
    chk("misalign addr held", mem_addr[1], 32'd0);
    idle(1);
    step(1'b0, 1'b1, BASE + 32'h100);
    step(1'b1, 1'b0, '0);
    chk("range fault", 32'(fault[2]), 32'd1);
    idle(1);
    step(1'b0, 1'b1, BASE + 32'h4);
    step(1'b1, 1'b0, '0);
    chk("fault cleared", 32'(fault[1]), 32'd0);
    idle(5);

    // Same-cycle fetch_start and pc_write
    step(1'b0, 1'b1, BASE + 32'h4);
    step(1'b1, 1'b1, BASE + 32'h8);
    chk("same-cycle mem_addr", mem_addr[1], 32'd1);
    chk("same-cycle pc", pc[1], 32'h0040_0008);
    chk("same-cycle old_pc", old_pc[1], 32'h0040_0004);
    idle(5);

`ifdef PC_AUTOINC_EN
    step(1'b0, 1'b1, BASE + 32'h4);
    step(1'b1, 1'b0, '0);
    idle(3);
    chk("autoinc pc", pc[1], 32'h0040_0008);
    idle(2);
`endif

    // Reset asserted while the latency-3 unit is in WAIT
    step(1'b0, 1'b1, BASE + 32'h8);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("pre-reset busy", 32'(busy[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset abort done", 32'(done[2]), 32'd0);
    chk("reset abort pc", pc[2], 32'h0040_0000);
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      logic        f, w;
      logic [31:0] n;
      f = ($urandom_range(0, 99) < 35);
      w = ($urandom_range(0, 99) < 20);
      case ($urandom_range(0, 3))
        0:       n = BASE + 4 * $urandom_range(0, 63);
        1:       n = BASE + 4 * $urandom_range(64, 80);
        2:       n = BASE + $urandom_range(0, 255);
        default: n = BASE - 4 * $urandom_range(1, 8);
      endcase
      step(f, w, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
